// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a single FIFO with bounded bursts per grant.
// It also checks write acknowledges, counts beats and keeps sticky error flags.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   beat_count,
  output logic                          ack_err,
  output logic                          ovf_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   owner_reg, owner_next;
  logic [ID_W-1:0]   last_owner_reg, last_owner_next;
  logic [BC_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic              ack_pending_reg;
  logic              ack_err_reg;
  logic              ovf_err_reg;
  logic [15:0]       beat_count_reg;
  logic [ID_W-1:0]   pick;
  logic              xfer;

  logic [FIFO_WIDTH-1:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
      assign req_ready[gi] = xfer && (owner_reg == ID_W'(gi));
    end
  endgenerate

  // Later offsets are overwritten by earlier ones, so the nearest valid
  // requester after last_owner wins.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_owner_reg) + k) % NUM_REQ;
      if (req_valid[ID_W'(idx)]) pick = ID_W'(idx);
    end
  end

  assign xfer         = (state_reg == GRANT) && req_valid[owner_reg] && !fifo_full;
  assign fifo_wr_en   = xfer;
  assign fifo_data_in = (state_reg == GRANT) ? data_arr[owner_reg] : '0;
  assign grant_id     = owner_reg;
  assign busy         = (state_reg == GRANT);
  assign beat_count   = beat_count_reg;
  assign ack_err      = ack_err_reg;
  assign ovf_err      = ovf_err_reg;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    burst_cnt_next  = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          owner_next     = pick;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (burst_cnt_reg == BC_W'(MAX_BURST - 1)) begin
            state_next      = IDLE;
            last_owner_next = owner_reg;
          end else begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
        end else if (!req_valid[owner_reg]) begin
          // Owner dropped valid: release even mid-burst; a full FIFO just stalls.
          state_next      = IDLE;
          last_owner_next = owner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      last_owner_reg  <= ID_W'(NUM_REQ - 1);
      burst_cnt_reg   <= '0;
      ack_pending_reg <= 1'b0;
      ack_err_reg     <= 1'b0;
      ovf_err_reg     <= 1'b0;
      beat_count_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_owner_reg  <= last_owner_next;
      burst_cnt_reg   <= burst_cnt_next;
      ack_pending_reg <= xfer;
      if (ack_pending_reg != fifo_wr_ack) ack_err_reg <= 1'b1;
      if (fifo_overflow) ovf_err_reg <= 1'b1;
      if (fifo_wr_ack) beat_count_reg <= beat_count_reg + 16'd1;
    end
  end

endmodule
